// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aurora_pkg
// Brief   : Shared constants and types for the Aurora RX NFC buffer slice.
// Revision: 1.0 - initial release
// ============================================================================
package aurora_pkg;

  localparam int          AURORA_DATA_W = 64;
  localparam logic [15:0] NFC_XOFF_WORD = 16'h0100;
  localparam logic [15:0] NFC_XON_WORD  = 16'h0000;

  typedef enum logic [1:0] {
    ST_FLOW_ON   = 2'd0,
    ST_SEND_XOFF = 2'd1,
    ST_FLOW_OFF  = 2'd2,
    ST_SEND_XON  = 2'd3
  } nfc_state_t;

endpackage
`default_nettype wire

// File: rtl/aurora_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : aurora_sync_fifo
// Brief   : First-word-fall-through synchronous FIFO with registered output.
// Revision: 1.0 - initial release
// ============================================================================
module aurora_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [AW:0] c_depth = CW'(DEPTH);
  localparam logic [AW:0] c_one   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic w_wr;
  logic w_rd_out;
  logic w_mem_empty;
  logic w_load;

  // Occupancy counts the output register too, so full is judged on r_count.
  assign full        = (r_count == c_depth);
  assign empty       = (r_count == '0);
  assign w_wr        = wr_en && !full;
  assign w_rd_out    = r_out_valid && rd_ready;
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_load      = !w_mem_empty && (!r_out_valid || rd_ready);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_load) begin
        r_rd_ptr    <= r_rd_ptr + c_one;
        r_out_data  <= r_mem[r_rd_ptr[AW-1:0]];
        r_out_valid <= 1'b1;
      end else if (w_rd_out) begin
        r_out_valid <= 1'b0;
      end
      case ({w_wr, w_rd_out})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data  = r_out_data;
  assign rd_valid = r_out_valid;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/aurora_rx_nfc_buffer.sv
`default_nettype none
// ============================================================================
// Module  : aurora_rx_nfc_buffer
// Brief   : Buffers the Aurora RX stream and throttles the far end via NFC.
// Revision: 1.0 - initial release
// ============================================================================
module aurora_rx_nfc_buffer
  import aurora_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int XOFF_THRESH = DEPTH - 64,
  parameter int XON_THRESH  = DEPTH / 4
) (
  input  logic                     aurora_userclk,
  input  logic                     aurora_rst_n,
  input  logic                     aurora_channel_up,
  input  logic [63:0]              s_axis_rx_tdata,
  input  logic                     s_axis_rx_tvalid,
  output logic [63:0]              m_axis_rx_tdata,
  output logic                     m_axis_rx_tvalid,
  input  logic                     m_axis_rx_tready,
  output logic [15:0]              m_axis_nfc_tdata,
  output logic                     m_axis_nfc_tvalid,
  input  logic                     m_axis_nfc_tready,
  output logic [$clog2(DEPTH):0]   rx_fill_level,
  output logic                     rx_overflow,
  output logic [15:0]              rx_drop_cnt
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_xoff = CW'(XOFF_THRESH);
  localparam logic [CW-1:0] c_xon  = CW'(XON_THRESH);

  logic          w_full;
  logic          w_unused_empty;
  logic [CW-1:0] w_count;
  logic          w_drop;

  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  nfc_state_t    r_state;
  nfc_state_t    w_state_nxt;
  logic          r_nfc_tvalid;
  logic          w_nfc_tvalid_nxt;
  logic [15:0]   r_nfc_tdata;
  logic [15:0]   w_nfc_tdata_nxt;

  aurora_sync_fifo #(
    .WIDTH (AURORA_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (aurora_userclk),
    .rst_n    (aurora_rst_n),
    .wr_en    (s_axis_rx_tvalid),
    .wr_data  (s_axis_rx_tdata),
    .rd_data  (m_axis_rx_tdata),
    .rd_valid (m_axis_rx_tvalid),
    .rd_ready (m_axis_rx_tready),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_unused_empty)
  );

  // Upstream has no ready: a word arriving while full is lost, even if a read retires this cycle.
  assign w_drop = s_axis_rx_tvalid && w_full;

  always_ff @(posedge aurora_userclk or negedge aurora_rst_n) begin
    if (!aurora_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge aurora_userclk or negedge aurora_rst_n) begin
    if (!aurora_rst_n) begin
      r_state      <= ST_FLOW_ON;
      r_nfc_tvalid <= 1'b0;
      r_nfc_tdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_nfc_tvalid <= w_nfc_tvalid_nxt;
      r_nfc_tdata  <= w_nfc_tdata_nxt;
    end
  end

  // A pending request is never abandoned on a threshold re-crossing; only channel loss aborts it.
  always_comb begin
    w_state_nxt = r_state;
    if (!aurora_channel_up) begin
      w_state_nxt = ST_FLOW_ON;
    end else begin
      case (r_state)
        ST_FLOW_ON:   if (w_count >= c_xoff)   w_state_nxt = ST_SEND_XOFF;
        ST_SEND_XOFF: if (m_axis_nfc_tready)   w_state_nxt = ST_FLOW_OFF;
        ST_FLOW_OFF:  if (w_count <= c_xon)    w_state_nxt = ST_SEND_XON;
        ST_SEND_XON:  if (m_axis_nfc_tready)   w_state_nxt = ST_FLOW_ON;
        default:                               w_state_nxt = ST_FLOW_ON;
      endcase
    end
  end

  always_comb begin
    w_nfc_tvalid_nxt = 1'b0;
    w_nfc_tdata_nxt  = '0;
    case (w_state_nxt)
      ST_SEND_XOFF: begin
        w_nfc_tvalid_nxt = 1'b1;
        w_nfc_tdata_nxt  = NFC_XOFF_WORD;
      end
      ST_SEND_XON: begin
        w_nfc_tvalid_nxt = 1'b1;
        w_nfc_tdata_nxt  = NFC_XON_WORD;
      end
      default: begin
        w_nfc_tvalid_nxt = 1'b0;
        w_nfc_tdata_nxt  = '0;
      end
    endcase
  end

  assign m_axis_nfc_tvalid = r_nfc_tvalid;
  assign m_axis_nfc_tdata  = r_nfc_tdata;
  assign rx_fill_level     = w_count;
  assign rx_overflow       = r_overflow;
  assign rx_drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_nfc_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aurora_rx_nfc_buffer
// Brief   : Self-checking bench for aurora_rx_nfc_buffer (DEPTH=16, 12/4 thresholds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_aurora_rx_nfc_buffer;

  localparam int DEPTH = 16;
  localparam int XOFF  = 12;
  localparam int XON   = 4;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        chan_up    = 1'b1;
  logic [63:0] rx_tdata   = '0;
  logic        rx_tvalid  = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready   = 1'b0;
  logic [15:0] nfc_tdata;
  logic        nfc_tvalid;
  logic        nfc_tready = 1'b0;
  logic [4:0]  fill;
  logic        ovf;
  logic [15:0] drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aurora_rx_nfc_buffer #(
    .DEPTH       (DEPTH),
    .XOFF_THRESH (XOFF),
    .XON_THRESH  (XON)
  ) u_dut (
    .aurora_userclk    (clk),
    .aurora_rst_n      (rst_n),
    .aurora_channel_up (chan_up),
    .s_axis_rx_tdata   (rx_tdata),
    .s_axis_rx_tvalid  (rx_tvalid),
    .m_axis_rx_tdata   (m_tdata),
    .m_axis_rx_tvalid  (m_tvalid),
    .m_axis_rx_tready  (m_tready),
    .m_axis_nfc_tdata  (nfc_tdata),
    .m_axis_nfc_tvalid (nfc_tvalid),
    .m_axis_nfc_tready (nfc_tready),
    .rx_fill_level     (fill),
    .rx_overflow       (ovf),
    .rx_drop_cnt       (drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: queue of accepted words, each tagged with the first edge it may be shown.
  typedef struct {
    logic [63:0] d;
    int          avail;
  } ent_t;

  ent_t q[$];
  ent_t mdl_e;
  logic mdl_hv   = 1'b0;
  int   mdl_pend = 0;      // 0 none, 1 XOFF pending, 2 XON pending
  logic mdl_off  = 1'b0;
  logic mdl_ovf  = 1'b0;
  int   mdl_drop = 0;
  int   mdl_occ;
  logic mdl_rd;
  logic mdl_wr;
  int   edge_n   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mdl_hv = 1'b0; mdl_pend = 0; mdl_off = 1'b0; mdl_ovf = 1'b0; mdl_drop = 0;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_fill", fill, 0);
      chk("rst_nfc_tvalid", nfc_tvalid, 0);
      chk("rst_drop", drop, 0);
    end else begin
      chk("m_tvalid", m_tvalid, mdl_hv);
      if (mdl_hv) chk("m_tdata", m_tdata, q[0].d);
      chk("fill", fill, q.size());
      chk("overflow", ovf, mdl_ovf);
      chk("drop_cnt", drop, mdl_drop);
      chk("nfc_tvalid", nfc_tvalid, mdl_pend != 0);
      chk("nfc_tdata", nfc_tdata, (mdl_pend == 1) ? 16'h0100 : 16'h0000);

      mdl_occ = q.size();
      mdl_rd  = mdl_hv && m_tready;
      mdl_wr  = rx_tvalid && (mdl_occ < DEPTH);
      if (rx_tvalid && !mdl_wr) begin
        mdl_ovf = 1'b1;
        if (mdl_drop < 65535) mdl_drop++;
      end
      if (!chan_up) begin
        mdl_off = 1'b0; mdl_pend = 0;
      end else if (mdl_pend != 0) begin
        if (nfc_tready) begin
          mdl_off  = (mdl_pend == 1);
          mdl_pend = 0;
        end
      end else if (!mdl_off && mdl_occ >= XOFF) begin
        mdl_pend = 1;
      end else if (mdl_off && mdl_occ <= XON) begin
        mdl_pend = 2;
      end
      if (mdl_rd) void'(q.pop_front());
      if (mdl_wr) begin
        mdl_e.d = rx_tdata; mdl_e.avail = edge_n + 1;
        q.push_back(mdl_e);
      end
      if (!(mdl_hv && !mdl_rd)) begin
        if (q.size() > 0) mdl_hv = (q[0].avail <= edge_n);
        else              mdl_hv = 1'b0;
      end
    end
    edge_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = base + 64'(i);
      step();
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((fill != 0 || m_tvalid) && n < 60) begin
      step();
      n++;
    end
    chk(name, (fill == 0) && !m_tvalid, 1);
  endtask

  initial begin
    int n;
    int got;

    step(); step();
    chk("reset_fill", fill, 0);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_nfc_tvalid", nfc_tvalid, 0);
    chk("reset_overflow", ovf, 0);
    rst_n = 1'b1;
    step();

    // Three words through an empty FIFO with the sink always ready.
    m_tready = 1'b1;
    rx_tvalid = 1'b1; rx_tdata = 64'hA0; step();
    chk("t1_latency_edge1", m_tvalid, 0);
    rx_tdata = 64'hA1; step();
    chk("t1_latency_edge2", m_tvalid, 1);
    chk("t1_word0", m_tdata, 64'hA0);
    rx_tdata = 64'hA2; step();
    chk("t1_word1", m_tdata, 64'hA1);
    rx_tvalid = 1'b0; step();
    chk("t1_word2", m_tdata, 64'hA2);
    step(); step();
    chk("t1_fill_zero", fill, 0);
    chk("t1_no_nfc", nfc_tvalid, 0);

    // Fill to XOFF threshold and stall the NFC handshake.
    m_tready = 1'b0; nfc_tready = 1'b0;
    wr_words(64'hB00, 12);
    chk("t2_fill12", fill, 12);
    chk("t2_nfc_not_yet", nfc_tvalid, 0);
    step();
    chk("t2_xoff_valid", nfc_tvalid, 1);
    chk("t2_xoff_word", nfc_tdata, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", nfc_tvalid, 1);
      chk("t2_hold_word", nfc_tdata, 16'h0100);
    end
    nfc_tready = 1'b1; step();
    chk("t2_xoff_accepted", nfc_tvalid, 0);
    nfc_tready = 1'b0;

    // Drain to XON threshold, then refill to XOFF again.
    m_tready = 1'b1;
    n = 0;
    while (!nfc_tvalid && n < 30) begin step(); n++; end
    chk("t3_xon_valid", nfc_tvalid, 1);
    chk("t3_xon_word", nfc_tdata, 16'h0000);
    chk("t3_xon_fill", fill, 3);
    nfc_tready = 1'b1;
    wait_empty("t3_drained");
    m_tready = 1'b0;
    wr_words(64'hC00, 12);
    step();
    chk("t3_xoff_again", nfc_tvalid, 1);
    chk("t3_xoff_again_word", nfc_tdata, 16'h0100);

    // Overflow: 18 writes into an empty 16-deep FIFO.
    m_tready = 1'b1;
    wait_empty("t4_pre_empty");
    m_tready = 1'b0;
    wr_words(64'hD00, 18);
    chk("t4_fill16", fill, 16);
    chk("t4_overflow", ovf, 1);
    chk("t4_drop2", drop, 2);
    m_tready = 1'b1;
    got = 0; n = 0;
    while (got < 16 && n < 40) begin
      if (m_tvalid) begin
        chk("t4_drain_word", m_tdata, 64'hD00 + 64'(got));
        got++;
      end
      step();
      n++;
    end
    chk("t4_drain_count", got, 16);
    step(); step();
    chk("t4_no_extra", m_tvalid, 0);
    chk("t4_sticky", ovf, 1);

    // Channel drop while XOFF pending, then return with occupancy 13.
    nfc_tready = 1'b0; m_tready = 1'b0;
    wr_words(64'hE00, 12);
    step();
    chk("t5_xoff_valid", nfc_tvalid, 1);
    chan_up = 1'b0; step();
    chk("t5_chan_down", nfc_tvalid, 0);
    rx_tvalid = 1'b1; rx_tdata = 64'hE0C; step();
    rx_tvalid = 1'b0;
    chk("t5_fill13", fill, 13);
    chan_up = 1'b1; step();
    chk("t5_xoff_resend", nfc_tvalid, 1);
    chk("t5_xoff_resend_word", nfc_tdata, 16'h0100);
    nfc_tready = 1'b1; step();
    chk("t5_xoff_accepted", nfc_tvalid, 0);

    // Asynchronous reset in the middle of traffic.
    m_tready = 1'b1;
    rx_tvalid = 1'b1; rx_tdata = 64'hF00; step();
    rx_tdata = 64'hF01; step();
    chk("t6_pre_fill_nonzero", fill != 0, 1);
    chk("t6_pre_overflow", ovf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_m_tvalid", m_tvalid, 0);
    chk("t6_async_m_tdata", m_tdata, 0);
    chk("t6_async_fill", fill, 0);
    chk("t6_async_overflow", ovf, 0);
    chk("t6_async_drop", drop, 0);
    chk("t6_async_nfc_tvalid", nfc_tvalid, 0);
    chk("t6_async_nfc_tdata", nfc_tdata, 0);
    rx_tvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_post_fill", fill, 0);
    chk("t6_post_drop", drop, 0);
    chk("t6_post_m_tvalid", m_tvalid, 0);
    wr_words(64'h1234, 2);
    chk("t6_post_first_word", m_tdata, 64'h1234);
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/aurora_rx_nfc_buffer.md
Name: aurora_rx_nfc_buffer

Overview:
- Receive-side stage directly downstream of the Aurora 64B66B core wrapper.
- The core's RX stream (m_axis_aurora_tdata/tvalid) has no backpressure, so this block absorbs it in a FIFO and re-presents it as a full AXI-Stream with tready.
- It drives the core's NFC interface (s_axis_aurora_nfc_*) with XOFF/XON requests based on FIFO occupancy, so the far end pauses before overflow.

Parameters:
- DEPTH, 512, FIFO depth in 64-bit words; power of two, minimum 16.
- XOFF_THRESH, DEPTH-64, occupancy at or above which XOFF is requested; the margin covers the far end's in-flight words.
- XON_THRESH, DEPTH/4, occupancy at or below which XON is requested; must be strictly less than XOFF_THRESH.

Ports:
- aurora_userclk  in  1  core user clock; the single clock of the block.
- aurora_rst_n  in  1  asynchronous active-low reset.
- aurora_channel_up  in  1  channel status from the core.
- s_axis_rx_tdata  in  64  RX data from the core.
- s_axis_rx_tvalid  in  1  RX valid from the core; no ready exists upstream.
- m_axis_rx_tdata  out  64  buffered data to the user logic.
- m_axis_rx_tvalid  out  1  buffered valid.
- m_axis_rx_tready  in  1  user-logic ready.
- m_axis_nfc_tdata  out  16  NFC word to the core.
- m_axis_nfc_tvalid  out  1  NFC request valid.
- m_axis_nfc_tready  in  1  NFC accept from the core.
- rx_fill_level  out  $clog2(DEPTH)+1  current occupancy.
- rx_overflow  out  1  sticky flag: a word was dropped.
- rx_drop_cnt  out  16  count of dropped words; saturates at 16'hFFFF.

Behaviour:
- Reset: one clock aurora_userclk; reset aurora_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FIFO empty; FSM in ST_FLOW_ON.
- Occupancy definition: words accepted and not yet handed out, including the output register.
  - Write: s_axis_rx_tvalid=1 while occupancy<DEPTH.
  - Read: m_axis_rx_tvalid & m_axis_rx_tready.
  - Simultaneous read and write leaves occupancy unchanged.
  - rx_fill_level is registered and reflects the previous cycle's updates.
- FIFO is first-word-fall-through with a registered output.
  - Latency from a write into an empty FIFO to m_axis_rx_tvalid=1 is 2 cycles.
  - m_axis_rx_tdata/tvalid are held stable while tvalid=1 and tready=0.
  - With continuous tready=1, sustained throughput is 1 word per cycle.
- Full: a write attempt at occupancy==DEPTH drops the word; the FIFO is unchanged.
  - rx_overflow is set and stays set until reset.
  - rx_drop_cnt increments, saturating.
  - A read in the same cycle does not rescue the dropped word; full is evaluated before the read.
- Pointers wrap modulo DEPTH; a full/empty distinction comes from an extra pointer MSB.
- NFC FSM, states and transitions:
  - ST_FLOW_ON -> ST_SEND_XOFF when occupancy>=XOFF_THRESH.
  - ST_SEND_XOFF: m_axis_nfc_tvalid=1, tdata=NFC_XOFF_WORD; -> ST_FLOW_OFF on tready.
  - ST_FLOW_OFF -> ST_SEND_XON when occupancy<=XON_THRESH.
  - ST_SEND_XON: m_axis_nfc_tvalid=1, tdata=NFC_XON_WORD; -> ST_FLOW_ON on tready.
- NFC handshake rules:
  - tvalid and tdata stay stable until tready.
  - The occupancy crossing back across the opposite threshold while in a SEND state does not abort that request; the FSM re-evaluates once in the following state.
  - m_axis_nfc_tvalid is registered; m_axis_nfc_tdata is 0 when tvalid=0.
- Channel down: aurora_channel_up=0 forces the FSM to ST_FLOW_ON next cycle from any state and drops nfc_tvalid.
  - FIFO contents are retained and keep draining.
  - On channel_up returning, normal threshold evaluation resumes; if occupancy>=XOFF_THRESH, XOFF is sent immediately.
- Writes are accepted regardless of channel_up; the core does not assert tvalid while the channel is down.
- Reset asserted mid-operation clears the FIFO, the FSM and the counters asynchronously; data in flight is lost.

Decomposition:
- Package aurora_pkg holds:
  - NFC_XOFF_WORD=16'h0100 (XOFF bit set, pause count 0).
  - NFC_XON_WORD=16'h0000.
  - AURORA_DATA_W=64.
  - typedef enum nfc_state_t {ST_FLOW_ON, ST_SEND_XOFF, ST_FLOW_OFF, ST_SEND_XON}.
- Sub-module aurora_sync_fifo: parameterised FWFT synchronous FIFO (width, depth) providing occupancy, full, empty and the registered output stage.
- The top holds the NFC FSM and the overflow/drop logic.

Test Plan (DEPTH=16, XOFF_THRESH=12, XON_THRESH=4):
- Write 3 words into an empty FIFO with tready=1 -> m_axis_rx_tvalid rises 2 cycles after the first write; data emerges in order; rx_fill_level returns to 0; no NFC activity.
- tready=0, write 12 words -> m_axis_nfc_tvalid=1 with tdata=16'h0100; hold nfc_tready=0 for 5 cycles -> tvalid/tdata stable; nfc_tready=1 -> FSM enters ST_FLOW_OFF and tvalid drops next cycle.
- From ST_FLOW_OFF at occupancy 12, drain with tready=1 -> at occupancy 4, nfc tdata=16'h0000 is sent; a subsequent refill to 12 sends XOFF again.
- tready=0, write 18 words -> 16 are stored; rx_overflow=1; rx_drop_cnt=2; draining yields exactly the first 16 words.
- In ST_SEND_XOFF, drop aurora_channel_up -> nfc_tvalid=0 next cycle and FSM in ST_FLOW_ON; raise channel_up with occupancy 13 -> XOFF is re-sent.
- Assert aurora_rst_n low mid-stream, asynchronously -> all outputs 0 without waiting for a clock edge; after release, the FIFO is empty and rx_drop_cnt=0.
